urv_shift_arb: RTL
==================

# urv_shift_arb

Arbiter and sequencer that shares one instance of the core's two-stage pipelined barrel shifter between two requesters, for example the execute stage and a bit-manipulation or debug unit. It drives the shifter's decode-side inputs and stall, tracks the single operation in flight through the shifter's pipe register, and captures results into a 2-entry response FIFO. The FIFO returns each result with the requester number and tag of the operation that produced it. Issue is credit-gated so a result can never be lost.

## Interface
- TAG_W, 4, width of the opaque per-request tag echoed on the response
- clk_i  in  1  clock
- rst_n_i  in  1  reset; synchronous, active-low
- req_valid_i  in  2  per-requester request valid (bit r = requester r)
- req_ready_o  out  2  per-requester grant/accept, one-hot or zero
- req0_rs1_i, req1_rs1_i  in  32  operand
- req0_shamt_i, req1_shamt_i  in  5  shift amount
- req0_fun_i, req1_fun_i  in  3  FUNC_SL / FUNC_SR
- req0_sign_i, req1_sign_i  in  1  arithmetic right shift
- req0_tag_i, req1_tag_i  in  TAG_W  tag
- sh_rs1_o, sh_shamt_o, sh_fun_o, sh_sign_o  out  32/5/3/1  to shifter d_rs1_i, d_shamt_i, d_fun_i, d_shifter_sign_i
- sh_valid_o  out  1  to shifter d_valid_i
- sh_stall_o  out  1  to shifter x_stall_i
- sh_rd_i  in  32  from shifter w_rd_o
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accept
- rsp_data_o  out  32  shift result
- rsp_id_o  out  1  requester number
- rsp_tag_o  out  TAG_W  echoed tag

## Operation
- State:
  - inflight (1 bit), plus inflight_id and inflight_tag
  - FIFO with 2 entries, wr/rd pointers and count 0..2
  - rr_ptr, the requester that has priority next
- Credit:
  - pop = rsp_valid_o & rsp_ready_i.
  - can_issue = (inflight + count − pop) < 2.
- Arbitration:
  - If can_issue is 0, req_ready_o = 0.
  - Otherwise the grant goes to the single valid requester.
  - If both requesters are valid, the grant goes to rr_ptr.
  - issue = |(req_valid_i & req_ready_o).
  - req_ready_o is combinational from req_valid_i, rr_ptr and the credit. It never asserts toward a requester whose valid is low.
- On issue:
  - The granted requester's fields are muxed onto sh_*.
  - sh_valid_o = 1 and sh_stall_o = 0, so the shifter pipe register loads.
  - inflight is set and inflight_id/inflight_tag are latched.
  - With round-robin, rr_ptr becomes the loser when both requesters were valid. Otherwise rr_ptr is unchanged.
- No issue: sh_stall_o = 1, sh_valid_o = 0 and sh_* hold the last issued values, which avoids toggling.
- When inflight is 1: sh_rd_i, inflight_id and inflight_tag are written into the FIFO at the clock edge. inflight then clears, unless a new issue happens in the same cycle, in which case it stays set.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- The credit rule guarantees a push never happens while count = 2 without a pop. An assertion checks this in simulation.
- Requester operands must be held stable while req_valid_i is high and the grant is not yet given.
- Requests are never dropped or reordered. Responses come out in issue order across both requesters.

## Timing
- Reset (rst_n_i low at a rising edge):
  - inflight = 0, count = 0, pointers = 0, rr_ptr = 0.
  - rsp_valid_o = 0, req_ready_o = 0, sh_valid_o = 0, sh_stall_o = 1, sh_* = 0.
  - Reset asserted mid-operation discards the in-flight operation and the FIFO contents. Nothing is emitted afterwards.
- Latency: accept in cycle N → shifter output valid in N+1 → FIFO write at the end of N+1 → rsp_valid_o high in N+2. Minimum latency is 2 cycles.
- Throughput: one issue per cycle sustained while rsp_ready_i stays high.
- Backpressure:
  - With rsp_ready_i low, at most 2 results are held (1 FIFO entry plus 1 in flight, then 2 FIFO entries).
  - req_ready_o stays low until a pop frees credit.
  - Because credit includes pop, issue resumes in the same cycle that rsp_ready_i rises.
- rsp_* are registered FIFO outputs and stay stable while rsp_valid_o & !rsp_ready_i.

## Configuration
- URV_SHIFT_ARB_RR_EN
  - Defined: round-robin arbitration as above.
  - Undefined: fixed priority, requester 0 always wins. rr_ptr is not implemented and requester 1 can starve.

## Test plan
- Single request: req0 rs1=0x80000001, shamt=4, FUNC_SR, sign=1, tag=5 → rsp in cycle N+2: data=0xF8000000, id=0, tag=5.
- Both requesters valid for 4 cycles with RR_EN, rsp_ready_i=1 → grants 0,1,0,1 and responses in that order, one per cycle. Without RR_EN → grants 0,0,0,0.
- rsp_ready_i held low, both requesters valid → exactly 2 issues then req_ready_o=0. Raise rsp_ready_i → 2 stored responses drain in order and issue resumes in the same cycle.
- FUNC_SL, rs1=0x00000003, shamt=31 → data=0x80000000. shamt=0 → data=0x00000003.
- Reset pulsed one cycle after an accept → no response is emitted, req_ready_o=0 during reset, normal issue on the first cycle after release.

Source files
------------

// File: rtl/urv_shift_arb.sv
// urv_shift_arb: shares one two-stage pipelined barrel shifter between two
// requesters. Drives the shifter decode inputs/stall, tracks the single
// operation in the shifter pipe register and captures results into a
// 2-entry response FIFO tagged with requester id and request tag.
// Issue is credit-gated so a result always has a FIFO slot.
//
// Build option: define URV_SHIFT_ARB_RR_EN for round-robin arbitration;
// when undefined, requester 0 has fixed priority.
module urv_shift_arb #(
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [31:0]      req0_rs1_i,
  input  logic [31:0]      req1_rs1_i,
  input  logic [4:0]       req0_shamt_i,
  input  logic [4:0]       req1_shamt_i,
  input  logic [2:0]       req0_fun_i,
  input  logic [2:0]       req1_fun_i,
  input  logic             req0_sign_i,
  input  logic             req1_sign_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output logic [31:0]      sh_rs1_o,
  output logic [4:0]       sh_shamt_o,
  output logic [2:0]       sh_fun_o,
  output logic             sh_sign_o,
  output logic             sh_valid_o,
  output logic             sh_stall_o,
  input  logic [31:0]      sh_rd_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_data_o,
  output logic             rsp_id_o,
  output logic [TAG_W-1:0] rsp_tag_o
);

  logic             inflight_q;
  logic             inflight_id_q;
  logic [TAG_W-1:0] inflight_tag_q;

  logic [31:0]      fifo_data_q [2];
  logic             fifo_id_q   [2];
  logic [TAG_W-1:0] fifo_tag_q  [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;

  // Last issued operands; held on the shifter inputs while idle.
  logic [31:0]      rs1_q;
  logic [4:0]       shamt_q;
  logic [2:0]       fun_q;
  logic             sign_q;

  logic             pop;
  logic             push;
  logic [2:0]       credit_used;
  logic             can_issue;
  logic             issue;
  logic             gnt_id;
  logic [1:0]       ready;

`ifdef URV_SHIFT_ARB_RR_EN
  logic             rr_ptr_q;
`endif

  assign pop  = rsp_valid_o & rsp_ready_i;
  assign push = inflight_q;

  // A pop in this cycle frees its slot immediately, so issue can resume
  // in the same cycle the consumer becomes ready.
  assign credit_used = {2'b00, inflight_q} + {1'b0, count_q} - {2'b00, pop};
  assign can_issue   = rst_n_i & (credit_used < 3'd2);

  // Grant selection: single valid requester wins; contention resolved by rr_ptr or fixed priority.
  always_comb begin
    ready  = 2'b00;
    gnt_id = 1'b0;
    if (can_issue) begin
      case (req_valid_i)
        2'b01: begin
          ready  = 2'b01;
          gnt_id = 1'b0;
        end
        2'b10: begin
          ready  = 2'b10;
          gnt_id = 1'b1;
        end
        2'b11: begin
`ifdef URV_SHIFT_ARB_RR_EN
          gnt_id = rr_ptr_q;
          ready  = rr_ptr_q ? 2'b10 : 2'b01;
`else
          gnt_id = 1'b0;
          ready  = 2'b01;
`endif
        end
        default: begin
          ready  = 2'b00;
          gnt_id = 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = ready;
  assign issue       = |(req_valid_i & ready);

  // Shifter decode inputs: granted requester on issue, otherwise hold last values.
  always_comb begin
    sh_rs1_o   = rs1_q;
    sh_shamt_o = shamt_q;
    sh_fun_o   = fun_q;
    sh_sign_o  = sign_q;
    if (issue) begin
      if (gnt_id) begin
        sh_rs1_o   = req1_rs1_i;
        sh_shamt_o = req1_shamt_i;
        sh_fun_o   = req1_fun_i;
        sh_sign_o  = req1_sign_i;
      end else begin
        sh_rs1_o   = req0_rs1_i;
        sh_shamt_o = req0_shamt_i;
        sh_fun_o   = req0_fun_i;
        sh_sign_o  = req0_sign_i;
      end
    end
  end

  assign sh_valid_o = issue;
  assign sh_stall_o = ~issue;

  // In-flight tracking, operand hold registers and FIFO pointers/count.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      inflight_q     <= 1'b0;
      inflight_id_q  <= 1'b0;
      inflight_tag_q <= '0;
      rs1_q          <= '0;
      shamt_q        <= '0;
      fun_q          <= '0;
      sign_q         <= 1'b0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
    end else begin
      // The previous op always drains into the FIFO this edge, so inflight
      // simply follows whether a new op enters the shifter.
      inflight_q <= issue;
      if (issue) begin
        inflight_id_q  <= gnt_id;
        inflight_tag_q <= gnt_id ? req1_tag_i : req0_tag_i;
        rs1_q          <= sh_rs1_o;
        shamt_q        <= sh_shamt_o;
        fun_q          <= sh_fun_o;
        sign_q         <= sh_sign_o;
      end
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // FIFO storage; contents are meaningless while count is zero so no reset.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && push) begin
      fifo_data_q[wr_ptr_q] <= sh_rd_i;
      fifo_id_q[wr_ptr_q]   <= inflight_id_q;
      fifo_tag_q[wr_ptr_q]  <= inflight_tag_q;
    end
  end

`ifdef URV_SHIFT_ARB_RR_EN
  // Round-robin pointer: after a contended grant the loser gets priority.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rr_ptr_q <= 1'b0;
    end else if (issue && (&req_valid_i)) begin
      rr_ptr_q <= ~rr_ptr_q;
    end
  end
`endif

  assign rsp_valid_o = (count_q != 2'd0);
  assign rsp_data_o  = fifo_data_q[rd_ptr_q];
  assign rsp_id_o    = fifo_id_q[rd_ptr_q];
  assign rsp_tag_o   = fifo_tag_q[rd_ptr_q];

  // Credit gating must make a push into a full FIFO impossible.
  fifo_overflow_chk: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(push && (count_q == 2'd2) && !pop));

endmodule
